softplus_pwl_pipe: RTL and testbench

Streaming, parametrised piecewise-constant-offset SoftPlus unit for the VAE datapath; computes y = max(x,0) + T[seg(x)] on signed fixed-point samples. Successor to the fixed 16-bit combinational offset block.
- Adds a 3-stage pipeline with valid/ready handshake.
- Adds a runtime-writable offset table of SEG entries and overflow detection.
- Sits between the encoder's variance-head accumulator and the reparameterisation stage.

---
 rtl/softplus_pwl_pipe.sv | 154 +++++++++++++++
 tb/tb_softplus_pwl_pipe.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/softplus_pwl_pipe.sv
// -----------------------------------------------------------------------------
// softplus_pwl_pipe
//   Streaming SoftPlus approximation y = max(x,0) + T[seg(x)] on signed
//   fixed-point samples. Three pipeline stages under a single global advance
//   enable, a runtime-writable offset table and a sticky overflow flag.
//
//   Build option: define SOFTPLUS_SAT_EN to clamp overflowing results to the
//   signed DATA_W range; left undefined, results wrap to the low DATA_W bits.
// -----------------------------------------------------------------------------
module softplus_pwl_pipe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int SEG    = 8,
  localparam int AW    = $clog2(SEG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              ovf_clr,
  output logic              ovf_sticky,
  output logic              busy
);

  // Default table entries are specified in Q.8; rescale to Q.FRAC_W.
  localparam int SHL = (FRAC_W > 8) ? FRAC_W - 8 : 0;
  localparam int SHR = (FRAC_W < 8) ? 8 - FRAC_W : 0;
  localparam logic [DATA_W-1:0] SEG_MAX = DATA_W'(SEG - 1);

  function automatic logic [DATA_W-1:0] reset_entry(input int i);
    logic signed [DATA_W-1:0] base;
    case (i)
      0:       base = DATA_W'(16'h004d);
      1:       base = DATA_W'(16'h0037);
      2:       base = DATA_W'(16'h001f);
      3:       base = DATA_W'(16'h000f);
      4:       base = DATA_W'(16'h0007);
      5:       base = DATA_W'(16'h0002);
      6:       base = DATA_W'(16'h0001);
      default: base = '0;
    endcase
    return $unsigned((base <<< SHL) >>> SHR);
  endfunction

  // Pipeline state
  logic              r_s0_valid;
  logic [DATA_W-1:0] r_s0_x;
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_t;
  logic [DATA_W-1:0] r_s1_relu;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_out_data;
  logic              r_ovf;
  logic [DATA_W-1:0] r_table [SEG];

  // Combinational datapath
  logic                     w_en;
  logic signed [DATA_W-1:0] w_ip;
  logic [DATA_W-1:0]        w_mag;
  logic [AW-1:0]            w_idx;
  logic [DATA_W-1:0]        w_relu;
  logic [DATA_W:0]          w_sum;
  logic                     w_ovf;
  logic [DATA_W-1:0]        w_res;

  // One enable advances every stage; the output stage only frees up when
  // it is empty or being drained this cycle.
  assign w_en       = ~r_s2_valid | out_ready;
  assign in_ready   = w_en;
  assign out_valid  = r_s2_valid;
  assign out_data   = r_out_data;
  assign ovf_sticky = r_ovf;
  assign busy       = r_s0_valid | r_s1_valid | r_s2_valid;

  // Segment index: integer part of x, mirrored for negatives so that
  // [-1,0) lands on segment 0 and [-k-1,-k) lands on segment k.
  assign w_ip   = $signed(r_s0_x) >>> FRAC_W;
  assign w_mag  = r_s0_x[DATA_W-1] ? ~w_ip : w_ip;
  assign w_relu = r_s0_x[DATA_W-1] ? '0 : r_s0_x;

  // Clamp the segment index to the last table entry.
  // NOTE: w_idx is assigned on every path, so no latch is inferred.
  always_comb begin
    w_idx = AW'(SEG - 1);
    if (w_mag <= SEG_MAX) w_idx = w_mag[AW-1:0];
  end

  // Sum in DATA_W+1 bits; overflow whenever the two top bits disagree.
  assign w_sum = {r_s1_relu[DATA_W-1], r_s1_relu} + {r_s1_t[DATA_W-1], r_s1_t};
  assign w_ovf = w_sum[DATA_W] ^ w_sum[DATA_W-1];

  // Result selection: clamp or wrap depending on the build.
  always_comb begin
    w_res = w_sum[DATA_W-1:0];
`ifdef SOFTPLUS_SAT_EN
    if (w_ovf) w_res = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                     : {1'b0, {(DATA_W-1){1'b1}}};
`else
    w_res = w_sum[DATA_W-1:0];
`endif
  end

  // Pipeline registers: all stages shift together on w_en, hold otherwise.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the pre-edge value of the stage behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
    end else if (w_en) begin
      r_s0_valid <= in_valid;
      r_s0_x     <= in_data;
      r_s1_valid <= r_s0_valid;
      r_s1_t     <= r_table[w_idx];
      r_s1_relu  <= w_relu;
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) r_out_data <= w_res;
    end
  end

  // Offset table: written independently of the pipeline enable; a lookup
  // at the same edge as a write sees the old entry.
  // NOTE: the table is a small register array, so it is reset explicitly to
  // its defaults; a RAM macro could not be restored this way.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEG; i++) r_table[i] <= reset_entry(i);
    end else if (cfg_we) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  // Sticky overflow: set when an overflowing sample enters S2, set wins
  // over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_en && r_s1_valid && w_ovf) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_softplus_pwl_pipe.sv
// -----------------------------------------------------------------------------
// tb_softplus_pwl_pipe
//   Directed bench for softplus_pwl_pipe with default parameters. Inputs are
//   driven and outputs sampled on the falling clock edge. Define
//   SOFTPLUS_SAT_EN consistently for bench and design.
// -----------------------------------------------------------------------------
module tb_softplus_pwl_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        ovf_clr;
  logic        ovf_sticky;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  softplus_pwl_pipe #(.DATA_W(16), .FRAC_W(8), .SEG(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .ovf_clr    (ovf_clr),
    .ovf_sticky (ovf_sticky),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
    end
  endtask

  // Send one sample, wait (bounded) for its result and compare it.
  task automatic run_one(input string tag, input logic [15:0] x, input logic [15:0] exp);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    check({tag, "_valid"}, 16'(out_valid), 16'h0001);
    check(tag, out_data, exp);
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  logic [15:0] bp_x   [6] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0600, 16'h0700};
  logic [15:0] bp_exp [6] = '{16'h0137, 16'h021F, 16'h030F, 16'h0407, 16'h0601, 16'h0700};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sent;
    int          got;
    logic        held_v;
    logic [15:0] held;
    logic [15:0] ovf_exp;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; ovf_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_out_valid", 16'(out_valid), 16'h0000);
    check("rst_busy", 16'(busy), 16'h0000);
    check("rst_in_ready", 16'(in_ready), 16'h0001);
    check("rst_ovf", 16'(ovf_sticky), 16'h0000);
    check("rst_out_data", out_data, 16'h0000);

    // 1. Positive lookup with exact 3-cycle latency
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0080;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_c1", 16'(out_valid), 16'h0000);
    @(negedge clk);
    check("lat_c2", 16'(out_valid), 16'h0000);
    @(negedge clk);
    check("lat_c3", 16'(out_valid), 16'h0001);
    check("pos_0080", out_data, 16'h00CD);
    @(negedge clk);
    check("lat_single", 16'(out_valid), 16'h0000);
    run_one("pos_0500", 16'h0500, 16'h0502);

    // 2. Negative mirror and index clamp
    run_one("neg_FF80", 16'hFF80, 16'h004D);
    run_one("neg_FC00", 16'hFC00, 16'h000F);
    run_one("neg_8000", 16'h8000, 16'h0000);

    // 3. Back-pressure: 6 samples, out_ready low for 5 cycles mid-stream
    sent = 0; got = 0; held_v = 1'b0; held = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 4 && cyc < 9);
      if (sent < 6) begin
        in_valid = 1'b1;
        in_data  = bp_x[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && held_v) check("bp_hold", out_data, held);
      if (out_valid && !out_ready) begin
        check("bp_in_ready", 16'(in_ready), 16'h0000);
        held   = out_data;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (got < 6) check("bp_data", out_data, bp_exp[got]);
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 16'(got), 16'd6);

    // 4. Table write, then write racing a lookup of the same index
    cfg_write(3'd0, 16'h0100);
    run_one("tw_idx0", 16'h0000, 16'h0100);
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'hFE80;
    @(negedge clk);
    in_data = 16'hFE80;
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 16'h0040;
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    check("race_old_valid", 16'(out_valid), 16'h0001);
    check("race_old", out_data, 16'h0037);
    @(negedge clk);
    check("race_new_valid", 16'(out_valid), 16'h0001);
    check("race_new", out_data, 16'h0040);

    // 5. Overflow and sticky flag
`ifdef SOFTPLUS_SAT_EN
    ovf_exp = 16'h7FFF;
`else
    ovf_exp = 16'h8080;
`endif
    check("ovf_pre", 16'(ovf_sticky), 16'h0000);
    cfg_write(3'd7, 16'h0100);
    run_one("ovf_data", 16'h7F80, ovf_exp);
    check("ovf_set", 16'(ovf_sticky), 16'h0001);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_clr", 16'(ovf_sticky), 16'h0000);

    // 6. Reset with three samples in flight; cfg write during reset ignored
    @(negedge clk);
    in_valid = 1'b1; in_data = 16'h0080;
    @(negedge clk);
    in_data = 16'h0500;
    @(negedge clk);
    in_data = 16'hFF80;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_busy_pre", 16'(busy), 16'h0001);
    rst = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 16'h1234;
    @(negedge clk);
    rst = 1'b0; cfg_we = 1'b0;
    #1;
    check("mid_busy", 16'(busy), 16'h0000);
    check("mid_in_ready", 16'(in_ready), 16'h0001);
    check("mid_out_data", out_data, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      check("mid_no_out", 16'(out_valid), 16'h0000);
      @(negedge clk);
    end
    run_one("mid_t0_restored", 16'h0000, 16'h004D);
    run_one("mid_t7_restored", 16'h7F80, 16'h7F80);
    check("mid_ovf", 16'(ovf_sticky), 16'h0000);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
